// File: rtl/laser_rx_pkg.sv
// Shared receive-path definitions for the 8b/10b lane.
// Symbol width, K28.7 comma codes and aligner states.
package laser_rx_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_7_RDN = 10'b0011111000;
  localparam logic [SYM_W-1:0] K28_7_RDP = 10'b1100000111;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } align_st_t;

  function automatic logic is_k28_7(
    input logic [SYM_W-1:0] win
  );
    return (win == K28_7_RDN) ||
           (win == K28_7_RDP);
  endfunction

endpackage

// File: rtl/comma_detect.sv
// K28.7 comma matcher over a 10-bit window.
// Either running disparity counts as a hit.
module comma_detect
  import laser_rx_pkg::*;
(
  input  logic [SYM_W-1:0] win,
  output logic             hit
);

  assign hit = is_k28_7(win);

endmodule

// File: rtl/comma_aligner.sv
// Serial-to-symbol aligner: hunts K28.7, qualifies
// the phase, then delivers 10-bit symbols.
module comma_aligner
  import laser_rx_pkg::*;
#(
  parameter int LOCK_COUNT    = 3,
  parameter int UNLOCK_COUNT  = 4,
  parameter int COMMA_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             realign,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             sym_is_comma,
  output logic             locked,
  output logic [3:0]       align_offset
);

  localparam int TMO_W =
    (COMMA_TIMEOUT > 0) ? $clog2(COMMA_TIMEOUT + 1) : 1;
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);
  localparam logic [TMO_W-1:0] TMO_N =
    TMO_W'(COMMA_TIMEOUT);
  localparam bit TMO_ON = (COMMA_TIMEOUT != 0);

  align_st_t        state;
  logic [8:0]       sr;
  logic [3:0]       phase;
  logic [3:0]       bitcnt;
  logic [3:0]       good_cnt;
  logic [3:0]       miss_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic [SYM_W-1:0] window;
  logic             hit_raw;
  logic             hit;
  logic             boundary;
  logic [3:0]       good_inc;
  logic [3:0]       miss_inc;
  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_exp;

  logic             adopt;
  logic             emit;
  logic             go_hunt;
  logic             go_lock;
  logic [3:0]       good_nxt;
  logic [3:0]       miss_nxt;
  logic [TMO_W-1:0] tmo_nxt;

  assign window   = {sr, bit_in};
  assign hit      = hit_raw & bit_valid & ~realign;
  assign boundary = (phase == 4'd9);

  assign good_inc = (&good_cnt) ? good_cnt
                                : good_cnt + 4'd1;
  assign miss_inc = (&miss_cnt) ? miss_cnt
                                : miss_cnt + 4'd1;
  assign tmo_inc  = (&tmo_cnt) ? tmo_cnt
                               : tmo_cnt + TMO_W'(1);
  assign tmo_exp  = TMO_ON && (tmo_inc >= TMO_N);

  comma_detect u_det (
    .win (window),
    .hit (hit_raw)
  );

  // Decide adoption, emission and state moves for this bit.
  always_comb begin
    adopt    = 1'b0;
    emit     = 1'b0;
    go_hunt  = realign;
    go_lock  = 1'b0;
    good_nxt = good_cnt;
    miss_nxt = miss_cnt;
    tmo_nxt  = tmo_cnt;
    if (!realign && bit_valid) begin
      unique case (state)
        ST_HUNT: adopt = hit;
        ST_VERIFY: begin
          if (hit && !boundary) begin
            adopt = 1'b1;
          end else if (boundary) begin
            emit = 1'b1;
            if (hit) begin
              good_nxt = good_inc;
              tmo_nxt  = '0;
              go_lock  = (good_inc >= LOCK_N);
            end else begin
              tmo_nxt = tmo_inc;
              go_hunt = tmo_exp;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            emit = 1'b1;
            if (hit) begin
              miss_nxt = '0;
              tmo_nxt  = '0;
            end else begin
              tmo_nxt = tmo_inc;
              go_hunt = tmo_exp;
            end
          end else if (hit) begin
            miss_nxt = miss_inc;
            go_hunt  = (miss_inc >= UNLOCK_N);
          end
        end
        default: go_hunt = 1'b1;
      endcase
    end
    if (adopt) begin
      emit     = 1'b1;
      good_nxt = 4'd1;
      miss_nxt = '0;
      tmo_nxt  = '0;
      go_lock  = (LOCK_N <= 4'd1);
    end
  end

  // Shift register, counters, FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      sr           <= '0;
      phase        <= '0;
      bitcnt       <= '0;
      good_cnt     <= '0;
      miss_cnt     <= '0;
      tmo_cnt      <= '0;
      sym_out      <= '0;
      sym_valid    <= 1'b0;
      sym_is_comma <= 1'b0;
      locked       <= 1'b0;
      align_offset <= '0;
    end else begin
      sym_valid <= emit;
      if (emit) begin
        sym_out      <= window;
        sym_is_comma <= hit;
      end
      if (bit_valid) begin
        sr     <= window[8:0];
        bitcnt <= (bitcnt == 4'd9) ? 4'd0
                                   : bitcnt + 4'd1;
        if (adopt || boundary) begin
          phase <= 4'd0;
        end else begin
          phase <= phase + 4'd1;
        end
      end
      if (adopt) begin
        align_offset <= bitcnt;
      end
      if (go_hunt) begin
        state    <= ST_HUNT;
        locked   <= 1'b0;
        good_cnt <= '0;
        miss_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        good_cnt <= good_nxt;
        miss_cnt <= miss_nxt;
        tmo_cnt  <= tmo_nxt;
        if (go_lock) begin
          state  <= ST_LOCKED;
          locked <= 1'b1;
        end else if (adopt) begin
          state <= ST_VERIFY;
        end
      end
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed table-driven bench for comma_aligner.
// Symbols are sent MSB first; checks follow the last bit.
module tb_comma_aligner;

  localparam logic [9:0] CN = 10'b0011111000;
  localparam logic [9:0] CP = 10'b1100000111;
  localparam logic [9:0] DD = 10'b1010101010;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       realign;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       sym_is_comma;
  logic       locked;
  logic [3:0] align_offset;

  int n_vec;
  int n_err;
  int nbits;

  typedef struct {
    logic [4:0] pad;
    int         pad_n;
    logic [9:0] sym;
    logic       gap;
    logic       rl;
    logic       valid;
    logic       comma;
    logic       lock;
    logic       chk_off;
  } vec_t;

  vec_t tbl[43];

  comma_aligner #(
    .LOCK_COUNT    (3),
    .UNLOCK_COUNT  (4),
    .COMMA_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .realign      (realign),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .sym_is_comma (sym_is_comma),
    .locked       (locked),
    .align_offset (align_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] pad,
    input int         pad_n,
    input logic [9:0] sym,
    input logic       gap,
    input logic       rl,
    input logic       valid,
    input logic       comma,
    input logic       lock,
    input logic       chk_off
  );
    vec_t v;
    v.pad     = pad;
    v.pad_n   = pad_n;
    v.sym     = sym;
    v.gap     = gap;
    v.rl      = rl;
    v.valid   = valid;
    v.comma   = comma;
    v.lock    = lock;
    v.chk_off = chk_off;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input int          idx,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic bit1(input logic b, input logic rl);
    @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    realign   = rl;
    @(posedge clk);
    #1;
    nbits++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      realign   = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input int i);
    vec_t v;
    v = tbl[i];
    for (int j = v.pad_n - 1; j >= 0; j--) begin
      bit1(v.pad[j], 1'b0);
      if (v.gap) idle(1);
    end
    for (int j = 9; j >= 0; j--) begin
      bit1(v.sym[j], (j == 0) ? v.rl : 1'b0);
      if (v.gap && j != 0) idle(1);
    end
    chk("sym_valid", i, 32'(sym_valid), 32'(v.valid));
    chk("locked", i, 32'(locked), 32'(v.lock));
    if (v.valid) begin
      chk("sym_out", i, 32'(sym_out), 32'(v.sym));
      chk("comma", i, 32'(sym_is_comma), 32'(v.comma));
    end
    if (v.chk_off) begin
      chk("offset", i, 32'(align_offset),
          32'((nbits - 1) % 10));
    end
    if (v.gap) begin
      idle(1);
      if (v.valid) begin
        chk("valid_fall", i, 32'(sym_valid), 32'd0);
      end
    end
  endtask

  task automatic chk_zero(input int idx);
    chk("rst_sym_out", idx, 32'(sym_out), 32'd0);
    chk("rst_valid", idx, 32'(sym_valid), 32'd0);
    chk("rst_comma", idx, 32'(sym_is_comma), 32'd0);
    chk("rst_locked", idx, 32'(locked), 32'd0);
    chk("rst_offset", idx, 32'(align_offset), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    nbits     = 0;
    rst_n     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    realign   = 1'b0;

    // gapped lock: garbage 010, CN D CP D CN
    tbl[0]  = mk(5'b00010, 3, CN, 1, 0, 1, 1, 0, 1);
    tbl[1]  = mk(5'b0, 0, DD, 1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(5'b0, 0, CP, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(5'b0, 0, DD, 1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(5'b0, 0, CN, 1, 0, 1, 1, 1, 0);
    // four commas shifted by 3 bits, then re-lock
    tbl[5]  = mk(5'b00101, 3, CP, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(5'b0, 0, CN, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(5'b0, 0, CP, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(5'b0, 0, CN, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(5'b0, 0, CP, 0, 0, 1, 1, 0, 1);
    tbl[10] = mk(5'b0, 0, CN, 0, 0, 1, 1, 0, 0);
    tbl[11] = mk(5'b0, 0, CP, 0, 0, 1, 1, 1, 1);
    // timeout after 16 comma-free boundaries
    for (int k = 0; k < 16; k++) begin
      tbl[12 + k] = mk(5'b0, 0, DD, 0, 0, 1, 0,
                       (k < 15) ? 1'b1 : 1'b0, 0);
    end
    tbl[28] = mk(5'b0, 0, DD, 0, 0, 0, 0, 0, 0);
    // verify phase jump by +5
    tbl[29] = mk(5'b0, 0, CN, 0, 0, 1, 1, 0, 0);
    tbl[30] = mk(5'b0, 0, DD, 0, 0, 1, 0, 0, 0);
    tbl[31] = mk(5'b0, 0, CP, 0, 0, 1, 1, 0, 0);
    tbl[32] = mk(5'b01010, 5, CN, 0, 0, 1, 1, 0, 1);
    tbl[33] = mk(5'b0, 0, DD, 0, 0, 1, 0, 0, 0);
    tbl[34] = mk(5'b0, 0, CP, 0, 0, 1, 1, 0, 0);
    tbl[35] = mk(5'b0, 0, DD, 0, 0, 1, 0, 0, 0);
    tbl[36] = mk(5'b0, 0, CN, 0, 0, 1, 1, 1, 0);
    // realign on the last bit of a comma
    tbl[37] = mk(5'b0, 0, CP, 0, 1, 0, 0, 0, 0);
    tbl[38] = mk(5'b0, 0, DD, 0, 0, 0, 0, 0, 0);
    tbl[39] = mk(5'b0, 0, CN, 0, 0, 1, 1, 0, 1);
    // after mid-stream reset
    tbl[40] = mk(5'b0, 0, DD, 0, 0, 0, 0, 0, 0);
    tbl[41] = mk(5'b0, 0, DD, 0, 0, 0, 0, 0, 0);
    tbl[42] = mk(5'b0, 0, CP, 0, 0, 1, 1, 0, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) apply(i);

    // sym_valid is high here; async reset must clear it now
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero(101);
    @(negedge clk);
    bit_valid = 1'b0;
    realign   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nbits = 0;

    for (int i = 40; i < 43; i++) apply(i);

    idle(2);
    chk("idle_valid", 102, 32'(sym_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
